// File: rtl/eq_pkg.sv
// Shared types and sizing helpers for the band mixer and its output stage.
package eq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Ceiling log2. Callers pass values >= 2, so the result is at least 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Wide enough that summing every band at full scale cannot wrap.
  function automatic int acc_width(input int audio_width, input int gain_width,
                                   input int num_bands);
    return audio_width + gain_width + 1 + clog2(num_bands);
  endfunction

  function automatic int unity_gain(input int gain_frac);
    return 1 << gain_frac;
  endfunction

endpackage

// File: rtl/eq_round_sat.sv
// Combinational round-half-up, arithmetic shift and saturation, with a clip flag.
module eq_round_sat #(
  parameter int IN_W  = 37,
  parameter int OUT_W = 24,
  parameter int SHIFT = 6
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout,
  output logic             clip
);

  // Half an output LSB; evaluates to zero when SHIFT is 0.
  localparam logic [IN_W:0] RND = ({{IN_W{1'b0}}, 1'b1} << SHIFT) >> 1;
  localparam logic signed [IN_W:0] MAX_V =
    $signed({{(IN_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}});
  localparam logic signed [IN_W:0] MIN_V =
    $signed({{(IN_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}});

  logic signed [IN_W:0] rounded;
  logic signed [IN_W:0] shifted;

  // One guard bit so the rounding add cannot overflow.
  assign rounded = $signed({din[IN_W-1], din}) + $signed(RND);
  assign shifted = rounded >>> SHIFT;

  always_comb begin
    clip = 1'b0;
    dout = shifted[OUT_W-1:0];
    if (shifted > MAX_V) begin
      clip = 1'b1;
      dout = MAX_V[OUT_W-1:0];
    end else if (shifted < MIN_V) begin
      clip = 1'b1;
      dout = MIN_V[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/eq_band_mixer.sv
// Time-multiplexed gain/sum mixer: one band per cycle through a shared multiplier.
module eq_band_mixer
  import eq_pkg::*;
#(
  parameter int NUM_BANDS   = 10,
  parameter int AUDIO_WIDTH = 24,
  parameter int GAIN_WIDTH  = 8,
  parameter int GAIN_FRAC   = 6,
  parameter int OUT_SHIFT   = 6
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_BANDS*AUDIO_WIDTH-1:0] bands_in,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             gain_we,
  input  logic [clog2(NUM_BANDS)-1:0]      gain_addr,
  input  logic [GAIN_WIDTH-1:0]            gain_wdata,
  input  logic                             gain_commit,
  output logic [AUDIO_WIDTH-1:0]           audio_out,
  output logic                             out_valid,
  output logic                             clip
);

  localparam int ADDR_W = clog2(NUM_BANDS);
  localparam int PROD_W = AUDIO_WIDTH + GAIN_WIDTH + 1;
  localparam int ACC_W  = acc_width(AUDIO_WIDTH, GAIN_WIDTH, NUM_BANDS);
  localparam logic [GAIN_WIDTH-1:0] UNITY = GAIN_WIDTH'(unity_gain(GAIN_FRAC));

  state_t                         state;
  logic signed [AUDIO_WIDTH-1:0]  bands_q [NUM_BANDS];
  logic [GAIN_WIDTH-1:0]          shadow  [NUM_BANDS];
  logic [GAIN_WIDTH-1:0]          active  [NUM_BANDS];
  logic                           commit_pending;
  logic [ADDR_W-1:0]              idx;
  logic signed [ACC_W-1:0]        acc;
  logic signed [PROD_W-1:0]       prod;
  logic signed [ACC_W-1:0]        prod_ext;
  logic                           addr_ok;
  logic [AUDIO_WIDTH-1:0]         rs_out;
  logic                           rs_clip;

  // Handshake: a sample transfers on any edge where in_valid and in_ready are
  // both high; the source holds bands_in stable until then.
  assign in_ready = (state == IDLE);

  assign prod     = bands_q[idx] * $signed({1'b0, active[idx]});
  assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
  assign addr_ok  = ({1'b0, gain_addr} < (ADDR_W + 1)'(NUM_BANDS));

  eq_round_sat #(
    .IN_W  (ACC_W),
    .OUT_W (AUDIO_WIDTH),
    .SHIFT (OUT_SHIFT)
  ) u_round_sat (
    .din  (acc),
    .dout (rs_out),
    .clip (rs_clip)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      acc            <= '0;
      idx            <= '0;
      audio_out      <= '0;
      out_valid      <= 1'b0;
      clip           <= 1'b0;
      commit_pending <= 1'b0;
      for (int k = 0; k < NUM_BANDS; k++) begin
        bands_q[k] <= '0;
        shadow[k]  <= UNITY;
        active[k]  <= UNITY;
      end
    end else begin
      out_valid <= 1'b0;
      if (gain_we && addr_ok) shadow[gain_addr] <= gain_wdata;
      if (gain_commit) commit_pending <= 1'b1;

      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int k = 0; k < NUM_BANDS; k++)
              bands_q[k] <= $signed(bands_in[k*AUDIO_WIDTH +: AUDIO_WIDTH]);
            acc   <= '0;
            idx   <= '0;
            state <= MAC;
            // Commit lands here so active gains stay frozen for the whole sample;
            // a same-edge shadow write is forwarded into the copy.
            if (commit_pending || gain_commit) begin
              for (int k = 0; k < NUM_BANDS; k++)
                active[k] <= (gain_we && gain_addr == ADDR_W'(k)) ? gain_wdata : shadow[k];
              commit_pending <= 1'b0;
            end
          end
        end
        MAC: begin
          acc <= acc + prod_ext;
          idx <= idx + 1'b1;
          if (idx == ADDR_W'(NUM_BANDS - 1)) state <= OUT;
        end
        OUT: begin
          audio_out <= rs_out;
          clip      <= rs_clip;
          out_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eq_band_mixer.sv
// Directed bench for eq_band_mixer with an output scoreboard.
module tb_eq_band_mixer;

  localparam int NB = 10;
  localparam int AW = 24;
  localparam int GW = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NB*AW-1:0]  bands_in = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              gain_we = 1'b0;
  logic [3:0]        gain_addr = '0;
  logic [GW-1:0]     gain_wdata = '0;
  logic              gain_commit = 1'b0;
  logic [AW-1:0]     audio_out;
  logic              out_valid;
  logic              clip;

  int total = 0;
  int bad   = 0;

  logic [AW-1:0] exp_q[$];
  logic          exp_clip_q[$];

  eq_band_mixer #(
    .NUM_BANDS(NB), .AUDIO_WIDTH(AW), .GAIN_WIDTH(GW), .GAIN_FRAC(6), .OUT_SHIFT(6)
  ) dut (
    .clk(clk), .rst(rst), .bands_in(bands_in), .in_valid(in_valid), .in_ready(in_ready),
    .gain_we(gain_we), .gain_addr(gain_addr), .gain_wdata(gain_wdata),
    .gain_commit(gain_commit), .audio_out(audio_out), .out_valid(out_valid), .clip(clip)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every out_valid pulse pops one expected result.
  always @(negedge clk) begin
    if (out_valid) begin
      check("unexpected_out", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        check("audio", 32'(exp_q.pop_front()), 32'(audio_out));
        check("clip", 32'(exp_clip_q.pop_front()), 32'(clip));
      end
    end
  end

  function automatic logic [NB*AW-1:0] all_bands(input logic [AW-1:0] v);
    logic [NB*AW-1:0] r;
    for (int k = 0; k < NB; k++) r[k*AW +: AW] = v;
    return r;
  endfunction

  function automatic logic [NB*AW-1:0] one_band(input int idx, input logic [AW-1:0] v);
    logic [NB*AW-1:0] r;
    r = '0;
    r[idx*AW +: AW] = v;
    return r;
  endfunction

  // All drivers start and end at posedge+1.
  task automatic write_gain(input logic [3:0] addr, input logic [GW-1:0] data,
                            input logic commit);
    gain_we = 1'b1; gain_addr = addr; gain_wdata = data; gain_commit = commit;
    @(posedge clk); #1;
    gain_we = 1'b0; gain_commit = 1'b0;
  endtask

  task automatic send(input logic [NB*AW-1:0] b, input logic [AW-1:0] exp,
                      input logic exp_clip);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_wait", 32'(in_ready), 32'd1);
    bands_in = b;
    in_valid = 1'b1;
    exp_q.push_back(exp);
    exp_clip_q.push_back(exp_clip);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_audio", 32'(audio_out), 32'd0);
    check("rst_clip", 32'(clip), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Unity gains with exact latency and ready profile.
    send(all_bands(24'd1000), 24'd10000, 1'b0);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      check("busy_ready", 32'(in_ready), 32'd0);
      check("busy_valid", 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    check("lat_valid", 32'(out_valid), 32'd1);
    check("lat_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    drain();

    // Saturation both ways.
    send(all_bands(24'h7FFFFF), 24'h7FFFFF, 1'b1);
    drain();
    send(all_bands(24'h800000), 24'h800000, 1'b1);
    drain();

    // Shadow write without commit, then commit pulsed mid-sample.
    write_gain(4'd3, 8'd128, 1'b0);
    send(one_band(3, 24'd100), 24'd100, 1'b0);
    @(posedge clk); #1;
    gain_commit = 1'b1;
    @(posedge clk); #1;
    gain_commit = 1'b0;
    drain();
    send(one_band(3, 24'd100), 24'd200, 1'b0);
    drain();

    // Rounding: only band0 contributes, with gain 1/64.
    for (int k = 1; k < NB; k++) write_gain(4'(k), 8'd0, 1'b0);
    write_gain(4'd0, 8'd1, 1'b1);
    send(one_band(0, 24'd32), 24'd1, 1'b0);
    drain();
    send(one_band(0, 24'hFFFFDF), 24'hFFFFFF, 1'b0);
    drain();
    send(one_band(0, 24'hFFFFE0), 24'd0, 1'b0);
    drain();

    // Reset during the fourth MAC cycle discards the sample and restores gains.
    send(all_bands(24'd1000), 24'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    exp_clip_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_audio", 32'(audio_out), 32'd0);
    @(posedge clk); #1;
    send(all_bands(24'd1000), 24'd10000, 1'b0);
    drain();

    // Out-of-range address is ignored.
    write_gain(4'd12, 8'd0, 1'b1);
    send(all_bands(24'd1000), 24'd10000, 1'b0);
    drain();

    // Write, commit and acceptance on one edge: new gain applies immediately.
    gain_we = 1'b1; gain_addr = 4'd0; gain_wdata = 8'd0; gain_commit = 1'b1;
    bands_in = all_bands(24'd1000);
    in_valid = 1'b1;
    exp_q.push_back(24'd9000);
    exp_clip_q.push_back(1'b0);
    @(posedge clk); #1;
    gain_we = 1'b0; gain_commit = 1'b0; in_valid = 1'b0;
    drain();

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
